// File: rtl/hist_stream.sv
// hist_stream: frame histogram engine with backpressured sample input,
// valid/ready result output, saturating bin counts, multi-frame accumulation
// and an optional cumulative (CDF) readout.
module hist_stream #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          keep,
    input  logic          cdf_mode,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    input  logic          din_last,
    output logic          din_rdy,
    output logic [DW-1:0] dout_bin,
    output logic [CW-1:0] dout,
    output logic          dout_vld,
    output logic          dout_last,
    input  logic          dout_rdy,
    output logic          busy,
    output logic          ovf
);

    localparam int unsigned NB      = 1 << DW;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [DW-1:0] BIN_MAX = {DW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CALC,
        S_FLUSH,
        S_OUTPUT
    } state_t;

    state_t        state_q, state_d;
    logic          mem_ok_q, mem_ok_d;
    logic          cdf_q, cdf_d;
    logic [DW-1:0] ptr_q, ptr_d;        // clear address, flush counter, output bin
    logic          rd_en_q, rd_en_d;    // rd_data_q holds mem[ptr_q] (OUTPUT)
    logic          done_q, done_d;      // last bin loaded into output register
    logic          s1_vld_q, s1_vld_d;  // RMW stage: read data for s1_addr_q arrives
    logic [DW-1:0] s1_addr_q, s1_addr_d;
    logic          fw_vld_q, fw_vld_d;  // write committed on the edge of the pending read
    logic [DW-1:0] fw_addr_q, fw_addr_d;
    logic [CW-1:0] fw_data_q, fw_data_d;
    logic [CW:0]   sum_q, sum_d;
    logic          din_rdy_q, din_rdy_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          dout_vld_q, dout_vld_d;
    logic [DW-1:0] dout_bin_q, dout_bin_d;
    logic [CW-1:0] dout_q, dout_d;
    logic          dout_last_q, dout_last_d;

    logic          mem_we;
    logic [DW-1:0] mem_waddr;
    logic [CW-1:0] mem_wdata;
    logic [DW-1:0] mem_raddr;
    logic [CW-1:0] rd_data_q;
    logic [CW-1:0] mem [NB];

    logic [CW-1:0] rmw_old;
    logic [CW-1:0] rmw_new;
    logic [CW:0]   sum_add;
    logic          load;

    // Bin RAM: one write port, one registered read port (read returns old data on collision)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem[mem_raddr];
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_ok_q    <= 1'b0;
            cdf_q       <= 1'b0;
            ptr_q       <= '0;
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            fw_vld_q    <= 1'b0;
            fw_addr_q   <= '0;
            fw_data_q   <= '0;
            sum_q       <= '0;
            din_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dout_vld_q  <= 1'b0;
            dout_bin_q  <= '0;
            dout_q      <= '0;
            dout_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_ok_q    <= mem_ok_d;
            cdf_q       <= cdf_d;
            ptr_q       <= ptr_d;
            rd_en_q     <= rd_en_d;
            done_q      <= done_d;
            s1_vld_q    <= s1_vld_d;
            s1_addr_q   <= s1_addr_d;
            fw_vld_q    <= fw_vld_d;
            fw_addr_q   <= fw_addr_d;
            fw_data_q   <= fw_data_d;
            sum_q       <= sum_d;
            din_rdy_q   <= din_rdy_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            dout_vld_q  <= dout_vld_d;
            dout_bin_q  <= dout_bin_d;
            dout_q      <= dout_d;
            dout_last_q <= dout_last_d;
        end
    end

    // Next state, RAM control, RMW update and output path
    always_comb begin
        state_d     = state_q;
        mem_ok_d    = mem_ok_q;
        cdf_d       = cdf_q;
        ptr_d       = ptr_q;
        rd_en_d     = rd_en_q;
        done_d      = done_q;
        s1_vld_d    = 1'b0;
        s1_addr_d   = s1_addr_q;
        fw_vld_d    = 1'b0;
        fw_addr_d   = fw_addr_q;
        fw_data_d   = fw_data_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        dout_vld_d  = dout_vld_q;
        dout_bin_d  = dout_bin_q;
        dout_d      = dout_q;
        dout_last_d = dout_last_q;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = '0;
        mem_raddr   = ptr_q;
        load        = 1'b0;
        sum_add     = sum_q + {1'b0, rd_data_q};

        // The write from the previous sample lands on the same edge as this
        // sample's read, so the RAM returns stale data; forward it instead.
        rmw_old = (fw_vld_q && (fw_addr_q == s1_addr_q)) ? fw_data_q : rd_data_q;
        rmw_new = (rmw_old == CNT_MAX) ? CNT_MAX : rmw_old + CW'(1);

        if (s1_vld_q) begin
            mem_we    = 1'b1;
            mem_waddr = s1_addr_q;
            mem_wdata = rmw_new;
            fw_vld_d  = 1'b1;
            fw_addr_d = s1_addr_q;
            fw_data_d = rmw_new;
            if (rmw_old == CNT_MAX) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    cdf_d = cdf_mode;
                    ptr_d = '0;
                    state_d = (keep && mem_ok_q) ? S_CALC : S_CLEAR;
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + DW'(1);
                if (ptr_q == BIN_MAX) begin
                    state_d  = S_CALC;
                    mem_ok_d = 1'b1;
                end
            end
            S_CALC: begin
                if (din_vld && din_rdy_q) begin
                    mem_raddr = din;
                    s1_vld_d  = 1'b1;
                    s1_addr_d = din;
                    if (din_last) begin
                        state_d = S_FLUSH;
                        ptr_d   = '0;
                    end
                end
            end
            S_FLUSH: begin
                ptr_d = ptr_q + DW'(1);
                if (ptr_q == DW'(2)) begin
                    state_d = S_OUTPUT;
                    ptr_d   = '0;
                    rd_en_d = 1'b0;
                    done_d  = 1'b0;
                    sum_d   = '0;
                end
            end
            S_OUTPUT: begin
                load = rd_en_q && (!dout_vld_q || dout_rdy);
                if (dout_vld_q && dout_rdy) begin
                    dout_vld_d = 1'b0;
                    if (dout_last_q) begin
                        state_d = S_IDLE;
                    end
                end
                if (load) begin
                    dout_vld_d  = 1'b1;
                    dout_bin_d  = ptr_q;
                    dout_last_d = (ptr_q == BIN_MAX);
                    if (cdf_q) begin
                        if (sum_add > {1'b0, CNT_MAX}) begin
                            sum_d = {1'b0, CNT_MAX};
                            ovf_d = 1'b1;
                        end else begin
                            sum_d = sum_add;
                        end
                        dout_d = sum_d[CW-1:0];
                    end else begin
                        dout_d = rd_data_q;
                    end
                    if (ptr_q == BIN_MAX) begin
                        rd_en_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d     = ptr_q + DW'(1);
                        mem_raddr = ptr_q + DW'(1);
                        rd_en_d   = 1'b1;
                    end
                end else begin
                    // Stalled or first cycle: (re)read the bin waiting to be loaded
                    mem_raddr = ptr_q;
                    rd_en_d   = !done_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        din_rdy_d = (state_d == S_CALC);
        busy_d    = (state_d != S_IDLE);
    end

    assign din_rdy   = din_rdy_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign dout_vld  = dout_vld_q;
    assign dout_bin  = dout_bin_q;
    assign dout      = dout_q;
    assign dout_last = dout_last_q;

endmodule

// File: tb/tb_hist_stream.sv
// Testbench for hist_stream: two instances (CW=20 and CW=4) driven in lockstep,
// checked against a count-array reference model plus hand-derived probe values.
module tb_hist_stream;

    localparam int unsigned DW   = 8;
    localparam int unsigned CWA  = 20;
    localparam int unsigned CWB  = 4;
    localparam int unsigned NB   = 256;
    localparam longint      MAXA = (64'd1 << CWA) - 1;
    localparam longint      MAXB = (64'd1 << CWB) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, keep = 1'b0, cdf_mode = 1'b0;
    logic [DW-1:0] din = '0;
    logic din_vld = 1'b0, din_last = 1'b0, dout_rdy = 1'b0;

    logic           a_din_rdy, a_dout_vld, a_dout_last, a_busy, a_ovf;
    logic [DW-1:0]  a_dout_bin;
    logic [CWA-1:0] a_dout;
    logic           b_din_rdy, b_dout_vld, b_dout_last, b_busy, b_ovf;
    logic [DW-1:0]  b_dout_bin;
    logic [CWB-1:0] b_dout;

    hist_stream #(.DW(DW), .CW(CWA)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .keep(keep), .cdf_mode(cdf_mode),
        .din(din), .din_vld(din_vld), .din_last(din_last), .din_rdy(a_din_rdy),
        .dout_bin(a_dout_bin), .dout(a_dout), .dout_vld(a_dout_vld),
        .dout_last(a_dout_last), .dout_rdy(dout_rdy), .busy(a_busy), .ovf(a_ovf)
    );

    hist_stream #(.DW(DW), .CW(CWB)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .keep(keep), .cdf_mode(cdf_mode),
        .din(din), .din_vld(din_vld), .din_last(din_last), .din_rdy(b_din_rdy),
        .dout_bin(b_dout_bin), .dout(b_dout), .dout_vld(b_dout_vld),
        .dout_last(b_dout_last), .dout_rdy(dout_rdy), .busy(b_busy), .ovf(b_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: true (unsaturated) totals per bin and per-run counts
    longint tot [NB];
    int     run_cnt [NB];
    bit     model_ok = 1'b0;
    bit     m_cdf = 1'b0;
    longint exp_a [NB];
    longint exp_b [NB];
    longint got_a [NB];
    longint got_b [NB];
    logic [DW-1:0] seq [$];

    typedef struct {
        bit     keep;
        bit     cdf;
        int     seq_id;
        int     rdy_pct;
        int     gap_pct;
        int     pb0;
        longint pa0;
        longint pbb0;
        int     pb1;
        longint pa1;
        longint pbb1;
        bit     ovf_a;
        bit     ovf_b;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_seq(input int id);
        seq.delete();
        case (id)
            0: for (int i = 0; i < 1024; i++) seq.push_back(8'(i % 256));
            1: begin
                seq.push_back(8'd7); seq.push_back(8'd7); seq.push_back(8'd7);
                seq.push_back(8'd3); seq.push_back(8'd7); seq.push_back(8'd3);
            end
            2: for (int i = 0; i < 100; i++) seq.push_back(8'd5);
            3: begin
                for (int i = 0; i < 50; i++) seq.push_back(8'd5);
                seq.push_back(8'd9);
            end
            4: for (int i = 0; i < 20; i++) seq.push_back(8'd2);
            5: for (int i = 0; i < 3; i++) seq.push_back(8'd2);
            default: begin
                seq.push_back(8'd0); seq.push_back(8'd1);
                seq.push_back(8'd1); seq.push_back(8'd255);
            end
        endcase
    endtask

    task automatic do_start(input bit k, input bit c);
        int lat;
        int exp_lat;
        exp_lat = (k && model_ok) ? 0 : 256;
        start = 1'b1; keep = k; cdf_mode = c;
        tick();
        start = 1'b0; keep = 1'($urandom); cdf_mode = 1'($urandom);
        if (!(k && model_ok)) begin
            for (int b = 0; b < NB; b++) tot[b] = 0;
        end
        model_ok = 1'b1;
        m_cdf = c;
        for (int b = 0; b < NB; b++) run_cnt[b] = 0;
        chk("ovf_a_after_start", a_ovf, 0);
        chk("ovf_b_after_start", b_ovf, 0);
        chk("busy_after_start", a_busy, 1);
        // Garbage samples flagged last while not ready must be ignored
        lat = 0;
        din_vld = 1'b1; din = 8'($urandom); din_last = 1'b1;
        while (!a_din_rdy && lat < 400) begin
            tick();
            lat++;
        end
        din_vld = 1'b0; din_last = 1'b0;
        chk("start_to_rdy_latency", lat, exp_lat);
        chk("b_din_rdy", b_din_rdy, 1);
    endtask

    task automatic send_frame(input int gap_pct, input int spur_pct);
        int not_rdy;
        not_rdy = 0;
        for (int i = 0; i < seq.size(); i++) begin
            if ($urandom_range(99) < gap_pct) begin
                din_vld = 1'b0; din = 8'($urandom); din_last = 1'($urandom);
                tick();
            end
            din = seq[i];
            din_vld = 1'b1;
            din_last = (i == seq.size() - 1);
            start = ($urandom_range(99) < spur_pct);
            keep = 1'($urandom); cdf_mode = 1'($urandom);
            if (!a_din_rdy) not_rdy++;
            tick();
            tot[seq[i]]++;
            run_cnt[seq[i]]++;
        end
        start = 1'b0; din_vld = 1'b0; din_last = 1'b0;
        chk("din_rdy_during_calc", not_rdy, 0);
        chk("din_rdy_drop_after_last", a_din_rdy, 0);
    endtask

    task automatic collect(input int rdy_pct, input int hold);
        longint cum_a, cum_b, sa, sb;
        bit ovf_ea, ovf_eb, first_seen, prev_stall, rdy;
        int nxt, cyc, held;
        logic [DW-1:0] p_bin;
        logic [CWA-1:0] p_dout;
        logic p_last;
        cum_a = 0; cum_b = 0; ovf_ea = 0; ovf_eb = 0;
        for (int b = 0; b < NB; b++) begin
            sa = (tot[b] > MAXA) ? MAXA : tot[b];
            sb = (tot[b] > MAXB) ? MAXB : tot[b];
            if (run_cnt[b] > 0 && tot[b] > MAXA) ovf_ea = 1;
            if (run_cnt[b] > 0 && tot[b] > MAXB) ovf_eb = 1;
            if (m_cdf) begin
                cum_a += sa; cum_b += sb;
                if (cum_a > MAXA) ovf_ea = 1;
                if (cum_b > MAXB) ovf_eb = 1;
                exp_a[b] = (cum_a > MAXA) ? MAXA : cum_a;
                exp_b[b] = (cum_b > MAXB) ? MAXB : cum_b;
            end else begin
                exp_a[b] = sa;
                exp_b[b] = sb;
            end
            got_a[b] = -1; got_b[b] = -1;
        end
        nxt = 0; cyc = 0; held = 0; first_seen = 0; prev_stall = 0;
        p_bin = '0; p_dout = '0; p_last = 1'b0;
        while (nxt < NB && cyc < 5000) begin
            if (a_dout_vld && !first_seen) begin
                first_seen = 1;
                chk("dout_vld_latency", cyc, 5);
            end
            if (prev_stall) begin
                chk("hold_vld", a_dout_vld, 1);
                chk("hold_bin", a_dout_bin, p_bin);
                chk("hold_dout", a_dout, p_dout);
                chk("hold_last", a_dout_last, p_last);
            end
            rdy = ($urandom_range(99) < rdy_pct);
            if (held < hold && a_dout_vld) begin
                rdy = 0;
                held++;
                if (held == hold) chk("busy_in_stall", a_busy, 1);
            end
            dout_rdy = rdy;
            start = ($urandom_range(9) == 0);
            if (a_dout_vld && rdy) begin
                chk($sformatf("bin_idx_a_%0d", nxt), a_dout_bin, nxt);
                chk($sformatf("bin_idx_b_%0d", nxt), b_dout_bin, nxt);
                chk($sformatf("dout_a_bin%0d", nxt), a_dout, exp_a[nxt]);
                chk($sformatf("dout_b_bin%0d", nxt), b_dout, exp_b[nxt]);
                chk($sformatf("dout_last_bin%0d", nxt), a_dout_last, (nxt == NB - 1));
                got_a[nxt] = a_dout;
                got_b[nxt] = b_dout;
                nxt++;
            end
            prev_stall = a_dout_vld && !rdy;
            p_bin = a_dout_bin; p_dout = a_dout; p_last = a_dout_last;
            tick();
            cyc++;
        end
        start = 1'b0; dout_rdy = 1'b0;
        chk("bins_transferred", nxt, NB);
        chk("dout_vld_after_last", a_dout_vld, 0);
        chk("busy_after_last", a_busy, 0);
        chk("ovf_a_end", a_ovf, ovf_ea);
        chk("ovf_b_end", b_ovf, ovf_eb);
    endtask

    task automatic rand_frame(input int len);
        int mode;
        logic [DW-1:0] va, vb;
        seq.delete();
        mode = $urandom_range(2);
        va = 8'($urandom); vb = 8'($urandom);
        for (int i = 0; i < len; i++) begin
            case (mode)
                0: seq.push_back(8'($urandom));
                1: seq.push_back(8'($urandom_range(3)));
                default: seq.push_back(($urandom_range(2) == 0) ? vb : va);
            endcase
        end
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 100,  0,   0,   4,  4, 255,   4,  4, 0, 0};
        vecs[1] = '{0, 0, 1, 100, 30,   7,   4,  4,   3,   2,  2, 0, 0};
        vecs[2] = '{0, 0, 2,  50,  0,   5, 100, 15,   9,   0,  0, 0, 1};
        vecs[3] = '{1, 0, 3, 100,  0,   5, 150, 15,   9,   1,  1, 0, 1};
        vecs[4] = '{0, 0, 4, 100,  0,   2,  20, 15,   3,   0,  0, 0, 1};
        vecs[5] = '{0, 0, 5, 100,  0,   2,   3,  3,   0,   0,  0, 0, 0};
        vecs[6] = '{0, 1, 6, 100,  0,   1,   3,  3, 255,   4,  4, 0, 0};

        // Reset state
        tick();
        tick();
        chk("rst_din_rdy", a_din_rdy, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_dout_vld", a_dout_vld, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_dout_bin", a_dout_bin, 0);
        chk("rst_dout_last", a_dout_last, 0);
        rst_n = 1'b1;

        // Samples in IDLE are ignored
        din_vld = 1'b1; din = 8'd5; din_last = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_din_rdy", a_din_rdy, 0);
        din_vld = 1'b0; din_last = 1'b0;

        // Directed frames
        for (int v = 0; v < 7; v++) begin
            build_seq(vecs[v].seq_id);
            do_start(vecs[v].keep, vecs[v].cdf);
            send_frame(vecs[v].gap_pct, 0);
            collect(vecs[v].rdy_pct, 0);
            chk($sformatf("v%0d_probe_a_bin%0d", v, vecs[v].pb0), got_a[vecs[v].pb0], vecs[v].pa0);
            chk($sformatf("v%0d_probe_b_bin%0d", v, vecs[v].pb0), got_b[vecs[v].pb0], vecs[v].pbb0);
            chk($sformatf("v%0d_probe_a_bin%0d", v, vecs[v].pb1), got_a[vecs[v].pb1], vecs[v].pa1);
            chk($sformatf("v%0d_probe_b_bin%0d", v, vecs[v].pb1), got_b[vecs[v].pb1], vecs[v].pbb1);
            chk($sformatf("v%0d_ovf_a", v), a_ovf, vecs[v].ovf_a);
            chk($sformatf("v%0d_ovf_b", v), b_ovf, vecs[v].ovf_b);
            tick();
        end

        // Single-sample frame, downstream stalled for a long time
        seq.delete();
        seq.push_back(8'd200);
        do_start(1, 0);
        send_frame(0, 0);
        collect(100, 60);
        chk("single_sample_bin200", got_a[200], 1);

        // Randomised frames with gaps, stalls and ignored start pulses
        for (int r = 0; r < 8; r++) begin
            rand_frame($urandom_range(1, 300));
            do_start(1'($urandom), 1'($urandom));
            send_frame(20, 10);
            collect(50, 0);
            tick();
        end

        // Asynchronous reset in the middle of CALC
        do_start(0, 0);
        din_vld = 1'b1; din_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = 8'($urandom);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_din_rdy", a_din_rdy, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_dout_vld", a_dout_vld, 0);
        chk("midrst_ovf", a_ovf, 0);
        chk("midrst_dout", a_dout, 0);
        chk("midrst_b_busy", b_busy, 0);
        din_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        model_ok = 1'b0;
        rand_frame(40);
        do_start(1, 0);
        send_frame(20, 0);
        collect(50, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
